// File: rtl/spram_frame_arbiter_pkg.sv
// Shared types and default sizes for the SPRAM frame-buffer arbiter.
// Used by the write FIFO, the bus interface and the arbiter top.
package fb_arb_pkg;

   localparam int ADDR_W_DEF      = 14;
   localparam int FRAME_WORDS_DEF = 9600;
   localparam int FIFO_DEPTH_DEF  = 4;
   localparam int ENTRY_W         = ADDR_W_DEF + 16;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      READ  = 2'd0,
      WRITE = 2'd1,
      IDLE  = 2'd2
   } slot_e;

   // A FIFO entry carries the word address above the 16-bit data word.
   function automatic int entry_w(input int addr_w);
      return addr_w + 16;
   endfunction

endpackage

// File: rtl/spram_frame_arbiter_if.sv
// Camera/VGA/SPRAM signal bundle for the frame arbiter.
// The master side is the surrounding system; the slave side is the arbiter.
interface spram_frame_arbiter_if #(parameter int ADDR_W = fb_arb_pkg::ADDR_W_DEF);

   logic              frame_start;
   logic              wr_valid;
   logic [7:0]        wr_pixel;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [15:0]       rd_data;
   logic              rd_data_valid;
   logic [ADDR_W-1:0] spram_ad;
   logic [15:0]       spram_di;
   logic              spram_we;
   logic [15:0]       spram_do;

   modport master (
      output frame_start, wr_valid, wr_pixel, rd_req, rd_addr, spram_do,
      input  rd_data, rd_data_valid, spram_ad, spram_di, spram_we
   );

   modport slave (
      input  frame_start, wr_valid, wr_pixel, rd_req, rd_addr, spram_do,
      output rd_data, rd_data_valid, spram_ad, spram_di, spram_we
   );

endinterface

// File: rtl/spram_frame_arbiter_fifo.sv
// fb_wr_fifo: small synchronous FIFO holding packed words awaiting a write slot.
// Push and pop may coincide, even when full (the pop frees the slot first).
module fb_wr_fifo #(
   parameter int WIDTH = fb_arb_pkg::ENTRY_W,
   parameter int DEPTH = fb_arb_pkg::FIFO_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W:0]   wr_ptr_r;
   logic [PTR_W:0]   rd_ptr_r;
   logic             do_pop_s;
   logic             do_push_s;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                      (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);
   assign dout      = mem_r[rd_ptr_r[PTR_W-1:0]];

   // Read and write pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r[PTR_W-1:0]] <= din;
   end

endmodule

// File: rtl/spram_frame_arbiter.sv
// Shares one SP256K between the camera pixel packer and the VGA reader; reads win every cycle.
// Optional power-up zero sweep of the frame buffer is built when SPRAM_CLEAR_EN is defined.
module spram_frame_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int FRAME_WORDS = FRAME_WORDS_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   spram_frame_arbiter_if.slave   bus,
   output logic                   busy,
   output logic                   overflow
);

   localparam int                EW        = entry_w(ADDR_W);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

   arb_state_e        state_s;
   slot_e             slot_s;
   logic [ADDR_W-1:0] clr_addr_s;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [7:0]        lo_byte_r;
   logic              have_lo_r;
   logic              pix_en_s;
   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;
   logic [EW-1:0]     push_entry_s;
   logic [EW-1:0]     pop_entry_s;
   logic [ADDR_W-1:0] wr_ad_s;
   logic [15:0]       wr_di_s;
   logic [ADDR_W-1:0] spram_ad_r;
   logic [15:0]       spram_di_r;
   logic              spram_we_r;
   logic              rd_pend_r;
   logic              rd_data_valid_r;
   logic              overflow_r;

`ifdef SPRAM_CLEAR_EN
   arb_state_e        state_r;
   arb_state_e        state_nx_s;
   logic [ADDR_W-1:0] clr_addr_r;
   logic              busy_r;

   // Sweep state, sweep address and busy flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= CLEAR;
         clr_addr_r <= '0;
         busy_r     <= 1'b1;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= (state_nx_s == CLEAR);
         if ((state_r == CLEAR) && (slot_s == WRITE)) clr_addr_r <= clr_addr_r + 1'b1;
      end
   end

   // Leave the sweep once the last frame address has been given a write slot
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         CLEAR: begin
            if (!bus.rd_req && (clr_addr_r == LAST_ADDR)) state_nx_s = RUN;
            else                                          state_nx_s = CLEAR;
         end
         RUN:     state_nx_s = RUN;
         default: state_nx_s = RUN;
      endcase
   end

   assign state_s    = state_r;
   assign clr_addr_s = clr_addr_r;
   assign busy       = busy_r;
`else
   assign state_s    = RUN;
   assign clr_addr_s = '0;
   assign busy       = 1'b0;
`endif

   // Slot choice: read first, then sweep or FIFO write, otherwise idle
   always_comb begin
      slot_s  = IDLE;
      pop_s   = 1'b0;
      wr_ad_s = pop_entry_s[EW-1:16];
      wr_di_s = pop_entry_s[15:0];
      if (bus.rd_req) begin
         slot_s = READ;
      end else if (state_s == CLEAR) begin
         slot_s  = WRITE;
         wr_ad_s = clr_addr_s;
         wr_di_s = 16'h0000;
      end else if (!empty_s) begin
         slot_s = WRITE;
         pop_s  = 1'b1;
      end else begin
         slot_s = IDLE;
      end
   end

   // Pixels are ignored during the sweep; frame_start drops any held low byte
   always_comb begin
      pix_en_s     = bus.wr_valid && (state_s == RUN);
      push_s       = pix_en_s && have_lo_r && !bus.frame_start;
      push_entry_s = {wr_addr_r, bus.wr_pixel, lo_byte_r};
   end

   // Pixel pairing and frame write address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr_r <= '0;
         lo_byte_r <= 8'h00;
         have_lo_r <= 1'b0;
      end else begin
         if (pix_en_s && (bus.frame_start || !have_lo_r)) lo_byte_r <= bus.wr_pixel;
         if (bus.frame_start) begin
            wr_addr_r <= '0;
            have_lo_r <= pix_en_s;
         end else if (pix_en_s) begin
            have_lo_r <= !have_lo_r;
            if (have_lo_r) wr_addr_r <= (wr_addr_r == LAST_ADDR) ? '0 : wr_addr_r + 1'b1;
         end
      end
   end

   fb_wr_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   (push_entry_s),
      .dout  (pop_entry_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // SPRAM port registers, read-valid pipeline and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spram_ad_r      <= '0;
         spram_di_r      <= 16'h0000;
         spram_we_r      <= 1'b0;
         rd_pend_r       <= 1'b0;
         rd_data_valid_r <= 1'b0;
         overflow_r      <= 1'b0;
      end else begin
         rd_pend_r       <= (slot_s == READ);
         rd_data_valid_r <= rd_pend_r;
         overflow_r      <= overflow_r | (push_s & full_s & ~pop_s);
         case (slot_s)
            READ: begin
               spram_ad_r <= bus.rd_addr;
               spram_we_r <= 1'b0;
            end
            WRITE: begin
               spram_ad_r <= wr_ad_s;
               spram_di_r <= wr_di_s;
               spram_we_r <= 1'b1;
            end
            IDLE:    spram_we_r <= 1'b0;
            default: spram_we_r <= 1'b0;
         endcase
      end
   end

   assign bus.spram_ad      = spram_ad_r;
   assign bus.spram_di      = spram_di_r;
   assign bus.spram_we      = spram_we_r;
   assign bus.rd_data_valid = rd_data_valid_r;
   assign bus.rd_data       = bus.spram_do;
   assign overflow          = overflow_r;

endmodule
